edge_det: RTL

Multi-channel, parametrised edge detector with optional input synchronisation, glitch filtering, per-channel mode select, sticky flags and saturating event counters. Successor to the single-bit registered rising-edge detector. It sits between asynchronous or noisy status inputs and control logic that needs single-cycle event pulses or software-visible event history. With SYNC_STAGES=0, FILTER_CYCLES=1 and mode=rising, channel behaviour is cycle-identical to the single-bit detector.

---
 rtl/edge_det_pkg.sv | 19 +
 rtl/edge_det_ch.sv | 88 ++++++++
 rtl/edge_det.sv | 41 ++++
 3 files changed

// File: rtl/edge_det_pkg.sv
// rtl/edge_det_pkg.sv - shared mode encoding and event qualification for edge_det
package edge_det_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF  = 2'b00;
    localparam mode_t MODE_RISE = 2'b01;
    localparam mode_t MODE_FALL = 2'b10;
    localparam mode_t MODE_BOTH = 2'b11;

    // new_level is the level just adopted, so 1 means a rise and 0 a fall
    function automatic logic mode_hit(input mode_t mode, input logic new_level);
        if (new_level)
            return (mode == MODE_RISE) || (mode == MODE_BOTH);
        else
            return (mode == MODE_FALL) || (mode == MODE_BOTH);
    endfunction

endpackage

// File: rtl/edge_det_ch.sv
// rtl/edge_det_ch.sv - one edge detector channel: synchroniser, glitch filter, pulse, sticky flag, counter
module edge_det_ch
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_sig,
    input  logic [1:0]           i_mode,
    input  logic                 i_clr,
    output logic                 o_level,
    output logic                 o_pulse,
    output logic                 o_flag,
    output logic [CNT_WIDTH-1:0] o_count
);

    localparam int                  KW      = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [KW-1:0]        K_LAST  = KW'(FILTER_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 w_s;
    logic                 w_change;
    logic                 w_event;
    logic [KW-1:0]        r_k;
    logic                 r_level;
    logic                 r_pulse;
    logic                 r_flag;
    logic [CNT_WIDTH-1:0] r_count;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = i_sig;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    r_sync <= '0;
                else
                    r_sync <= (r_sync << 1) | SYNC_STAGES'(i_sig);
            end
            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // The level flips only on the F-th consecutive sample that disagrees with it
    assign w_change = (w_s != r_level) && (r_k == K_LAST);
    assign w_event  = w_change && mode_hit(mode_t'(i_mode), w_s);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_k     <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_flag  <= 1'b0;
            r_count <= '0;
        end else begin
            if ((w_s == r_level) || w_change)
                r_k <= '0;
            else
                r_k <= r_k + KW'(1);

            if (w_change)
                r_level <= w_s;

            r_pulse <= w_event;
            r_flag  <= w_event | (r_flag & ~i_clr);

            // A clear coinciding with an event keeps that event
            if (w_event) begin
                if (i_clr)
                    r_count <= CNT_WIDTH'(1);
                else if (r_count != CNT_MAX)
                    r_count <= r_count + CNT_WIDTH'(1);
            end else if (i_clr) begin
                r_count <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;
    assign o_flag  = r_flag;
    assign o_count = r_count;

endmodule

// File: rtl/edge_det.sv
// rtl/edge_det.sv - multi-channel edge detector; replicates edge_det_ch and slices the buses
module edge_det
    import edge_det_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [CHANNELS-1:0]           i_sig,
    input  logic [2*CHANNELS-1:0]         i_mode,
    input  logic [CHANNELS-1:0]           i_clr,
    output logic [CHANNELS-1:0]           o_level,
    output logic [CHANNELS-1:0]           o_pulse,
    output logic [CHANNELS-1:0]           o_flag,
    output logic [CHANNELS*CNT_WIDTH-1:0] o_count
);

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            edge_det_ch #(
                .SYNC_STAGES  (SYNC_STAGES),
                .FILTER_CYCLES(FILTER_CYCLES),
                .CNT_WIDTH    (CNT_WIDTH)
            ) u_ch (
                .i_clk  (i_clk),
                .i_rst_n(i_rst_n),
                .i_sig  (i_sig[c]),
                .i_mode (i_mode[2*c +: 2]),
                .i_clr  (i_clr[c]),
                .o_level(o_level[c]),
                .o_pulse(o_pulse[c]),
                .o_flag (o_flag[c]),
                .o_count(o_count[c*CNT_WIDTH +: CNT_WIDTH])
            );
        end
    endgenerate

endmodule
